// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam int OVERSAMPLE  = 16;
  localparam int START_MID   = 7;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

endpackage

// File: rtl/uart_receiver_baud_tick_gen.sv
// Oversampling tick divider: s_tick_o pulses once every TICK_DIV clocks.
module baud_tick_gen #(
  parameter int N        = 1,
  parameter int TICK_DIV = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic s_tick_o
);

  localparam logic [N-1:0] CNT_LAST = N'(TICK_DIV - 1);

  logic [N-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // Masked during reset so no tick is seen while the block is held.
  assign s_tick_o = (cnt_q == CNT_LAST) && !reset_i;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, 16x oversampling, 2-flop rx synchronizer.
// Define UART_RX_FRAME_ERR_EN to add the frame_err output.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DBIT     = DEF_DBIT,
  parameter int SB_TICK  = DEF_SB_TICK,
  parameter int TICK_DIV = 1,
  parameter int N        = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic            frame_err
`endif
);

  localparam int            NW      = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
  localparam logic [3:0]    S_MID   = 4'(START_MID);
  localparam logic [3:0]    S_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    SB_LAST = 4'(SB_TICK - 1);

  logic s_tick;

  baud_tick_gen #(
    .N        (N),
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_i    (clk),
    .reset_i  (reset),
    .s_tick_o (s_tick)
  );

  state_e          state_q, state_d;
  logic [3:0]      s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            sync1_q, sync2_q;
  logic            rx_s;
`ifdef UART_RX_FRAME_ERR_EN
  logic            ferr_q, ferr_d;
`endif

  assign rx_s = sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      sync1_q <= rx;
      sync2_q <= sync1_q;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_q  <= ferr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_d  = ferr_q;
`endif
    case (state_q)
      // Start edge is detected on the raw clock, not on a tick.
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == S_LAST) begin
            b_d     = {rx_s, b_q[DBIT-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == N_LAST) state_d = STOP;
            else                   n_cnt_d = n_cnt_q + 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == SB_LAST) begin
            dout_d  = b_q;
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
            ferr_d  = ~rx_s;
`endif
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign frame_err    = ferr_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver (DBIT=8, TICK_DIV=1: 16 clocks per bit).
module tb_uart_receiver;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    logic [7:0] expDout;
    logic       expFerr;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] dout;
  logic       rxDoneTick;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frameErr;
`endif

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  int         pulseCycles[$];
  logic [7:0] pulseData[$];
  logic       pulseFerr[$];
  int         doubleHigh = 0;
  logic       prevDone = 1'b0;

  vec_t vecs[6];

  uart_receiver #(
    .DBIT     (8),
    .SB_TICK  (16),
    .TICK_DIV (1),
    .N        (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rxDoneTick)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err    (frameErr)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Record every done pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (rxDoneTick === 1'b1) begin
      pulseCycles.push_back(cycle);
      pulseData.push_back(dout);
`ifdef UART_RX_FRAME_ERR_EN
      pulseFerr.push_back(frameErr);
`else
      pulseFerr.push_back(1'b0);
`endif
      if (prevDone === 1'b1) doubleHigh++;
    end
    prevDone = rxDoneTick;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearPulses();
    pulseCycles.delete();
    pulseData.delete();
    pulseFerr.delete();
  endtask

  task automatic driveBit(input logic v);
    rx = v;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is aligned 1ns after a rising edge; the start edge is driven immediately.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, output int fallCycle);
    fallCycle = cycle;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    driveBit(stopBit);
    rx = 1'b1;
  endtask

  initial begin
    int fall, fall2, lat;
    logic [7:0] got;

    vecs[0] = '{data: 8'hFA, stopBit: 1'b1, expDout: 8'hFA, expFerr: 1'b0};
    vecs[1] = '{data: 8'h00, stopBit: 1'b1, expDout: 8'h00, expFerr: 1'b0};
    vecs[2] = '{data: 8'hFF, stopBit: 1'b1, expDout: 8'hFF, expFerr: 1'b0};
    vecs[3] = '{data: 8'h12, stopBit: 1'b0, expDout: 8'h12, expFerr: 1'b1};
    vecs[4] = '{data: 8'hC3, stopBit: 1'b1, expDout: 8'hC3, expFerr: 1'b0};
    vecs[5] = '{data: 8'h5A, stopBit: 1'b1, expDout: 8'h5A, expFerr: 1'b0};

    rx = 1'b1;
    reset = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    checkOutput("reset_dout", 32'(dout), 32'h00);
    checkOutput("reset_done", 32'(rxDoneTick), 32'h0);
`ifdef UART_RX_FRAME_ERR_EN
    checkOutput("reset_ferr", 32'(frameErr), 32'h0);
`endif
    reset = 1'b0;
    clearPulses();
    idle(16);
    checkOutput("idle_pulses", 32'(pulseCycles.size()), 32'd0);
    checkOutput("idle_dout", 32'(dout), 32'h00);

    for (int v = 0; v < 6; v++) begin
      clearPulses();
      applyStimulus(vecs[v].data, vecs[v].stopBit, fall);
      idle(40);
      checkOutput($sformatf("vec%0d_pulses", v), 32'(pulseCycles.size()), 32'd1);
      got = (pulseData.size() > 0) ? pulseData[0] : 8'hxx;
      checkOutput($sformatf("vec%0d_pulse_dout", v), 32'(got), 32'(vecs[v].expDout));
      checkOutput($sformatf("vec%0d_held_dout", v), 32'(dout), 32'(vecs[v].expDout));
      lat = (pulseCycles.size() > 0) ? pulseCycles[0] - fall : -1;
      checkOutput($sformatf("vec%0d_latency_in_152_156", v), 32'(lat >= 152 && lat <= 156), 32'd1);
`ifdef UART_RX_FRAME_ERR_EN
      checkOutput($sformatf("vec%0d_ferr", v), 32'((pulseFerr.size() > 0) ? pulseFerr[0] : 1'bx),
                  32'(vecs[v].expFerr));
`endif
    end

    // Short low glitch must be rejected at the start-bit midpoint.
    clearPulses();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(200);
    checkOutput("glitch_pulses", 32'(pulseCycles.size()), 32'd0);
    checkOutput("glitch_dout", 32'(dout), 32'h5A);

    clearPulses();
    applyStimulus(8'h55, 1'b1, fall);
    applyStimulus(8'hA3, 1'b1, fall2);
    idle(40);
    checkOutput("b2b_pulses", 32'(pulseCycles.size()), 32'd2);
    if (pulseCycles.size() == 2) begin
      checkOutput("b2b_first", 32'(pulseData[0]), 32'h55);
      checkOutput("b2b_second", 32'(pulseData[1]), 32'hA3);
      checkOutput("b2b_spacing", 32'(pulseCycles[1] - pulseCycles[0]), 32'd160);
    end
    checkOutput("b2b_dout", 32'(dout), 32'hA3);

    // Abort a 0x3C frame halfway through data bit 4.
    clearPulses();
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(1'(8'h3C >> i));
    rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(200);
    checkOutput("abort_pulses", 32'(pulseCycles.size()), 32'd0);
    checkOutput("abort_dout", 32'(dout), 32'h00);

    clearPulses();
    applyStimulus(8'h81, 1'b1, fall);
    idle(40);
    checkOutput("after_abort_pulses", 32'(pulseCycles.size()), 32'd1);
    checkOutput("after_abort_dout", 32'(dout), 32'h81);

    checkOutput("no_double_pulse", 32'(doubleHigh), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
